memaccess_mc: RTL and testbench

MEMACCESS_MC -- requirements
Module: memaccess_mc

---
 rtl/memaccess_mc.sv | 197 +++++++++++++++++++
 tb/tb_memaccess_mc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memaccess_mc.sv
// memaccess_mc: round-robin multi-channel access controller in front of a
// single-port word store. One transaction at a time: IDLE (arbitrate/grant),
// ACCESS (one storage operation), RESP (hold response until accepted).
// Optional build macro MEMACCESS_MC_STATS_EN adds per-channel completed
// response counters on port stat_count.
module memaccess_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_CH)-1:0]  rsp_ch,
    output logic [DATA_W-1:0]          rsp_rdata,
`ifdef MEMACCESS_MC_STATS_EN
    output logic [NUM_CH*16-1:0]       stat_count,
`endif
    output logic                       rsp_err
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Round-robin search start (channel after the last grant).
    logic [CH_W-1:0]   rr_ptr, rr_nxt;

    // Captured request for the transaction in flight.
    logic [CH_W-1:0]   cap_ch, cap_ch_nxt;
    logic              cap_we, cap_we_nxt;
    logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
    logic [DATA_W-1:0] cap_wdata, cap_wdata_nxt;

    // Response register next values.
    logic              rsp_valid_nxt;
    logic [CH_W-1:0]   rsp_ch_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic              rsp_err_nxt;

    // Arbiter results.
    logic              grant_any_c;
    logic [CH_W-1:0]   grant_idx_c;
    logic [CH_W-1:0]   cand_c;

    // Storage; intentionally never reset.
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we_c;
    logic              in_range_c;
    logic [IDX_W-1:0]  mem_idx_c;

    assign in_range_c = ({1'b0, cap_addr} < DEPTH_L);
    assign mem_idx_c  = cap_addr[IDX_W-1:0];

    // Round-robin pick: first valid channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            cand_c = CH_W'((int'(rr_ptr) + i) % int'(NUM_CH));
            if (!grant_any_c && req_valid[cand_c]) begin
                grant_any_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    // Next-state, handshake and datapath next values.
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rr_nxt        = rr_ptr;
        cap_ch_nxt    = cap_ch;
        cap_we_nxt    = cap_we;
        cap_addr_nxt  = cap_addr;
        cap_wdata_nxt = cap_wdata;
        rsp_valid_nxt = rsp_valid;
        rsp_ch_nxt    = rsp_ch;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        mem_we_c      = 1'b0;

        case (state)
            IDLE: begin
                // Grant is suppressed while reset is held so req_ready reads 0.
                if (grant_any_c && !reset) begin
                    req_ready     = NUM_CH'(1) << grant_idx_c;
                    cap_ch_nxt    = grant_idx_c;
                    cap_we_nxt    = req_we[grant_idx_c];
                    cap_addr_nxt  = req_addr[grant_idx_c * ADDR_W +: ADDR_W];
                    cap_wdata_nxt = req_wdata[grant_idx_c * DATA_W +: DATA_W];
                    rr_nxt        = (grant_idx_c == LAST_CH) ? '0 : grant_idx_c + CH_W'(1);
                    state_nxt     = ACCESS;
                end
            end

            ACCESS: begin
                mem_we_c      = cap_we && in_range_c;
                rsp_valid_nxt = 1'b1;
                rsp_ch_nxt    = cap_ch;
                rsp_err_nxt   = !in_range_c;
                rsp_rdata_nxt = (!cap_we && in_range_c) ? mem[mem_idx_c] : '0;
                state_nxt     = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, capture and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cap_ch    <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            cap_ch    <= cap_ch_nxt;
            cap_we    <= cap_we_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_wdata <= cap_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_ch    <= rsp_ch_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Storage write port; only reachable from ACCESS, which reset exits at once.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[mem_idx_c] <= cap_wdata;
        end
    end

`ifdef MEMACCESS_MC_STATS_EN
    logic [15:0] stat_q [NUM_CH];

    // Saturating count of accepted responses per channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                stat_q[i] <= '0;
            end
        end else if (state == RESP && rsp_ready) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (rsp_ch == CH_W'(i) && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        stat_count = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            stat_count[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_memaccess_mc.sv
// Self-checking bench for memaccess_mc (NUM_CH=4, ADDR_W=8, DATA_W=32, DEPTH=128).
module tb_memaccess_mc;

    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DEP = 128;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_we = '0;
    logic [NCH*AW-1:0] req_addr = '0;
    logic [NCH*DW-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_ch;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
`ifdef MEMACCESS_MC_STATS_EN
    logic [NCH*16-1:0] stat_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage: plain array plus "has been written" flags.
    logic [31:0] model_mem [0:255];
    bit          model_vld [0:255];

    typedef struct {
        int          ch;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt [12];

    memaccess_mc #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ch    (rsp_ch),
        .rsp_rdata (rsp_rdata),
`ifdef MEMACCESS_MC_STATS_EN
        .stat_count(stat_count),
`endif
        .rsp_err   (rsp_err)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_ch",    32'(rsp_ch),    32'd0);
        chk("reset rsp_rdata", rsp_rdata,      32'd0);
        chk("reset rsp_err",   32'(rsp_err),   32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Poll (at negedge+1) for any req_ready, bounded.
    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_rsp(output bit got);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            #1;
        end
    endtask

    // One complete transaction on one channel with response checks.
    task automatic run_txn(input int ch, input bit we, input logic [7:0] a, input logic [31:0] wd,
                           input int stall, input bit chk_rd, input logic [31:0] exp_rd,
                           input bit exp_err, input string nm);
        bit got;
        @(negedge clock);
        req_valid              = '0;
        req_valid[ch]          = 1'b1;
        req_we[ch]             = we;
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = wd;
        rsp_ready              = 1'b0;
        #1;
        wait_grant(got);
        chk({nm, " grant"}, 32'(req_ready), got ? 32'(4'b1 << ch) : 32'hFFFF_FFFF);
        if (!got) begin
            req_valid = '0;
            return;
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        chk({nm, " access no rsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clock);
        #1;
        chk({nm, " latency"}, 32'(rsp_valid), 32'd1);
        wait_rsp(got);
        if (!got) return;
        chk({nm, " ch"},  32'(rsp_ch),  32'(ch));
        chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
        if (chk_rd) chk({nm, " rdata"}, rsp_rdata, exp_rd);
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            #1;
            chk({nm, " held"}, 32'(rsp_valid), 32'd1);
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        #1;
        chk({nm, " released"}, 32'(rsp_valid), 32'd0);
    endtask

    // Transaction whose expectation comes from the reference storage.
    task automatic model_txn(input int ch, input bit we, input logic [7:0] a,
                             input logic [31:0] wd, input int stall, input string nm);
        bit          e;
        bit          c;
        logic [31:0] x;
        e = (int'(a) >= DEP);
        if (e || we) begin
            c = 1'b1;
            x = 32'd0;
        end else begin
            c = model_vld[a];
            x = model_mem[a];
        end
        run_txn(ch, we, a, wd, stall, c, x, e, nm);
        if (!e && we) begin
            model_mem[a] = wd;
            model_vld[a] = 1'b1;
        end
    endtask

    initial begin
        bit got;
        int k;
        int last_c;
        int idx;

        vt[0]  = '{0, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1]  = '{0, 1'b0, 8'h10, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{1, 1'b1, 8'h20, 32'h1234_5678, 1'b0, 32'h0};
        vt[3]  = '{3, 1'b0, 8'h20, 32'h0,         1'b0, 32'h1234_5678};
        vt[4]  = '{2, 1'b0, 8'hFF, 32'h0,         1'b1, 32'h0};
        vt[5]  = '{2, 1'b1, 8'h7F, 32'hA5A5_0001, 1'b0, 32'h0};
        vt[6]  = '{1, 1'b0, 8'h7F, 32'h0,         1'b0, 32'hA5A5_0001};
        vt[7]  = '{2, 1'b1, 8'h00, 32'h0000_0001, 1'b0, 32'h0};
        vt[8]  = '{3, 1'b1, 8'h80, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vt[9]  = '{0, 1'b0, 8'h80, 32'h0,         1'b1, 32'h0};
        vt[10] = '{1, 1'b0, 8'h00, 32'h0,         1'b0, 32'h0000_0001};
        vt[11] = '{2, 1'b1, 8'hFF, 32'h5555_AAAA, 1'b1, 32'h0};

        do_reset();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_txn(vt[i].ch, vt[i].we, vt[i].addr, vt[i].wdata, i % 3, 1'b1,
                    vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
            if (vt[i].we && int'(vt[i].addr) < DEP) begin
                model_mem[vt[i].addr] = vt[i].wdata;
                model_vld[vt[i].addr] = 1'b1;
            end
        end

        // Backpressure: response held 5 cycles, competing request not granted.
        @(negedge clock);
        req_valid = '0; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0 +: AW] = 8'h10;
        rsp_ready = 1'b0;
        #1;
        wait_grant(got);
        chk("bp grant", 32'(req_ready), got ? 32'h1 : 32'hFFFF_FFFF);
        @(negedge clock);
        req_valid = '0; req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'h10;
        #1;
        wait_rsp(got);
        chk("bp rsp seen", 32'(got), 32'd1);
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            #1;
            chk($sformatf("bp valid c%0d", s), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp ch c%0d", s),    32'(rsp_ch),    32'd0);
            chk($sformatf("bp rdata c%0d", s), rsp_rdata,      32'hDEAD_BEEF);
            chk($sformatf("bp err c%0d", s),   32'(rsp_err),   32'd0);
            chk($sformatf("bp no ready c%0d", s), 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        @(negedge clock);
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("dropped req not granted", 32'(req_ready), 32'd0);
            chk("bp idle no rsp", 32'(rsp_valid), 32'd0);
            @(negedge clock);
        end

        // Reset while in ACCESS abandons a pending write.
        req_valid = '0; req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr[1*AW +: AW] = 8'h20; req_wdata[1*DW +: DW] = 32'hBAD0_BAD0;
        #1;
        wait_grant(got);
        chk("rst grant", 32'(req_ready), got ? 32'h2 : 32'hFFFF_FFFF);
        @(negedge clock);
        reset = 1'b1;
        req_valid = '0;
        #1;
        chk("rst in access rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            #1;
            chk("rst no response", 32'(rsp_valid), 32'd0);
        end
        run_txn(1, 1'b0, 8'h20, 32'h0, 0, 1'b1, 32'h1234_5678, 1'b0, "rst readback");

        // Fairness: all channels request continuously from reset release.
        req_valid = '1;
        req_we    = '0;
        req_addr  = {8'h10, 8'h20, 8'h7F, 8'h00};
        rsp_ready = 1'b1;
        do_reset();
        #1;
        k = 0;
        last_c = 0;
        for (int c = 0; c < 200 && k < 12; c++) begin
            if (req_ready != '0) begin
                idx = 0;
                for (int b = 0; b < NCH; b++) if (req_ready[b]) idx = b;
                chk($sformatf("fair onehot %0d", k), 32'($countones(req_ready)), 32'd1);
                chk($sformatf("fair order %0d", k), 32'(idx), 32'(k % NCH));
                if (k == 0) chk("first grant right after reset", 32'(c), 32'd0);
                else        chk($sformatf("fair spacing %0d", k), 32'(c - last_c), 32'd3);
                last_c = c;
                k++;
            end
            @(negedge clock);
            #1;
        end
        chk("fair grant count", 32'(k), 32'd12);
        req_valid = '0;
        repeat (4) @(negedge clock);
        rsp_ready = 1'b0;

        // Randomized traffic against the reference storage.
        for (int t = 0; t < 60; t++) begin
            int          ch;
            bit          we;
            logic [7:0]  a;
            logic [31:0] wd;
            ch = $urandom_range(0, NCH - 1);
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 2) != 0) ? 8'($urandom_range(0, 15))
                                             : 8'($urandom_range(8'h78, 8'h87));
            wd = $urandom;
            model_txn(ch, we, a, wd, $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

`ifdef MEMACCESS_MC_STATS_EN
        do_reset();
        for (int t = 0; t < 3; t++) begin
            model_txn(3, 1'b0, 8'h10, 32'h0, t, $sformatf("stat%0d", t));
        end
        @(negedge clock);
        #1;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("stat ch%0d", i), 32'(stat_count[i*16 +: 16]), (i == 3) ? 32'd3 : 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
